lcd_hd44780_ctrl: RTL
=====================

# lcd_hd44780_ctrl

Parametrised HD44780-compatible character-LCD controller driving an 8-bit parallel bus, write-only. Host logic writes characters into an internal ROWS×COLS frame buffer at any time. The controller runs the power-on wait and the init sequence, then refreshes the whole buffer to the panel continuously. It generates proper E setup/pulse/hold timing and per-command execution waits, and sits between application logic and the LCD header pins.

## Interface
Parameters:
- COLS, 16, characters per row (1..40)
- ROWS, 2, display rows (1, 2 or 4)
- E_CYC, 16, clk cycles per E phase (setup, high, hold), ≥1
- CMD_WAIT, 2000, clk cycles idle after every byte except clear
- CLR_WAIT, 80000, clk cycles idle after clear command 0x01
- PWR_WAIT, 750000, clk cycles idle after reset before first command
- AW, derived: $clog2(ROWS*COLS), buffer address width

Ports (one clock `clk`; reset `rst_n` synchronous, active-low):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  buffer index = row*COLS + col
- wr_data  in  8  character code
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  constant 0
- lcd_en  out  1  E strobe
- lcd_dat  out  8  data bus
- init_done  out  1  high once init completes; sticky until reset
- frame_done  out  1  one-cycle pulse at the end of each full refresh

## Operation
- Reset values: lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_dat=0x00, init_done=0, frame_done=0. All buffer bytes = 0x20. FSM = PWR.
- States: PWR → INIT → REFRESH (loops forever). Any cycle with rst_n=0 returns to reset values on that edge, including mid-transfer and mid-wait.
- PWR: count PWR_WAIT cycles with bus idle.
- INIT: transfer commands 0x38, 0x0C, 0x06, 0x01 in order, rs=0. init_done rises on the cycle the 0x01 wait completes.
- REFRESH: for r = 0..ROWS-1, send command 0x80|base(r), then COLS data bytes (rs=1) from buffer[r*COLS+c], c ascending.
  - base: 0x00, 0x40, 0x14, 0x54.
  - After the last byte's wait: pulse frame_done, restart at r=0.
- Transfer engine (one byte), in order:
  - SETUP: rs/dat driven, en=0, E_CYC cycles
  - HIGH: en=1, E_CYC cycles
  - HOLD: en=0, rs/dat held, E_CYC cycles
  - WAIT: CLR_WAIT if byte is clear command, else CMD_WAIT
- rs and dat change only on the first SETUP cycle. They remain stable through HOLD and WAIT.
- Buffer writes:
  - A write with wr_en=1 and wr_addr < ROWS*COLS updates the byte on that edge, in any state including PWR/INIT.
  - Out-of-range addresses are ignored.
- The data byte is latched from the buffer on the edge entering SETUP. If a write lands on the same address at that same edge, the old value is sent and the new value appears next frame.

## Timing
- Byte transfer T = 3*E_CYC + WAIT cycles. En high exactly E_CYC cycles per byte; no en glitches between bytes.
- Init completion: init_done=1 exactly PWR_WAIT + 4*(3*E_CYC) + 3*CMD_WAIT + CLR_WAIT cycles after the first edge with rst_n=1.
- Frame period: ROWS*(COLS+1)*(3*E_CYC+CMD_WAIT) cycles. frame_done is high 1 cycle per frame, coincident with the last WAIT cycle of the frame.
- Write-to-display latency ≤ 1 frame period + T.

## Test plan
Bench parameters: COLS=4, ROWS=2, E_CYC=2, CMD_WAIT=4, CLR_WAIT=10, PWR_WAIT=20.
- Reset/init:
  - Release rst_n, observe bus.
  - Required: no en for 20 cycles.
  - Then en pulses carry 0x38, 0x0C, 0x06, 0x01 with rs=0; init_done rises at cycle 20+24+12+10=66.
- First frame:
  - After init with empty buffer, the sequence is 0x80, 0x20×4, 0xC0, 0x20×4.
  - Each en pulse is 2 cycles wide, 10 cycles apart.
  - frame_done pulses once, 100 cycles after init_done.
- Writes:
  - During PWR, write addr 0='H' and addr 5='i'.
  - Frame shows 0x80, 'H', 0x20, 0x20, 0x20, 0xC0, 0x20, 'i', 0x20, 0x20.
- Boundaries:
  - Write addr 8 (out of range): no buffer change.
  - Write addr 1 on the exact edge its SETUP begins: old byte sent this frame, new byte sent next frame.
- Mid-reset: assert rst_n=0 for one cycle while en=1.
  - Next edge: en=0, dat=0x00, init_done=0, buffer back to 0x20.
  - Full init re-runs (init_done again 66 cycles after release).

Source files
------------

// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl: HD44780 8-bit write-only controller that inits the panel and refreshes a frame buffer forever
module lcd_hd44780_ctrl #(
  parameter int COLS = 16,
  parameter int ROWS = 2,
  parameter int E_CYC = 16,
  parameter int CMD_WAIT = 2000,
  parameter int CLR_WAIT = 80000,
  parameter int PWR_WAIT = 750000,
  localparam int AW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic          lcd_en,
  output logic [7:0]    lcd_dat,
  output logic          init_done,
  output logic          frame_done
);
  localparam int N = ROWS * COLS;
  localparam int MX1 = PWR_WAIT > CLR_WAIT ? PWR_WAIT : CLR_WAIT;
  localparam int MX2 = MX1 > CMD_WAIT ? MX1 : CMD_WAIT;
  localparam int MX = MX2 > E_CYC ? MX2 : E_CYC;
  localparam int CW = $clog2(MX + 1);
  localparam int CBW = $clog2(COLS + 1);
  localparam logic [CW-1:0] E_L = CW'(E_CYC - 1);
  localparam logic [CW-1:0] CMD_L = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] CLR_L = CW'(CLR_WAIT - 1);
  localparam logic [CW-1:0] PWR_L = CW'(PWR_WAIT);
  localparam logic [CBW-1:0] C_L = CBW'(COLS);
  localparam logic [1:0] R_L = 2'(ROWS - 1);
  localparam logic [AW:0] N_L = (AW + 1)'(N);
  typedef enum logic [1:0] {PWR, INIT, REFR} st_t;
  typedef enum logic [1:0] {SETUP, HIGH, HOLD, WAIT} ph_t;
  st_t st, st_n;
  ph_t ph, ph_n;
  logic [CW-1:0] cnt, cnt_n, len;
  logic [1:0] ii, ii_n, r, r_n, pr;
  logic [CBW-1:0] c, c_n, pc;
  logic rs_n, done_q, ph_end, byte_end, init_last;
  logic [7:0] dat_n;
  logic [AW-1:0] rd;
  logic [7:0] mem [N];
  assign lcd_rw = 1'b0;
  // Sequencer: column 0 of each row is the set-DDRAM command, columns 1..COLS are characters
  always_comb begin
    len = ph == WAIT ? (!lcd_rs && lcd_dat == 8'h01 ? CLR_L : CMD_L) : E_L;
    ph_end = st != PWR && cnt == len;
    byte_end = ph_end && ph == WAIT;
    init_last = byte_end && st == INIT && ii == 2'd3;
    frame_done = byte_end && st == REFR && r == R_L && c == C_L;
    init_done = done_q || init_last;
    pr = st != REFR ? 2'd0 : c != C_L ? r : r == R_L ? 2'd0 : r + 2'd1;
    pc = st != REFR || c == C_L ? '0 : c + 1'b1;
    rd = AW'(int'(pr) * COLS + int'(pc) - 1);
    st_n = st;
    ph_n = ph;
    cnt_n = cnt + 1'b1;
    ii_n = ii;
    r_n = r;
    c_n = c;
    rs_n = lcd_rs;
    dat_n = lcd_dat;
    if (st == PWR && cnt == PWR_L) begin
      st_n = INIT;
      cnt_n = '0;
      dat_n = 8'h38;
    end else if (ph_end) begin
      cnt_n = '0;
      ph_n = ph_t'(ph + 2'd1);
      if (ph == WAIT && st == INIT && ii != 2'd3) begin
        ii_n = ii + 2'd1;
        dat_n = ii == 2'd0 ? 8'h0C : ii == 2'd1 ? 8'h06 : 8'h01;
      end else if (ph == WAIT) begin
        st_n = REFR;
        r_n = pr;
        c_n = pc;
        rs_n = pc != '0;
        dat_n = pc != '0 ? mem[rd] :
                8'h80 | (pr == 2'd1 ? 8'h40 : pr == 2'd2 ? 8'h14 : pr == 2'd3 ? 8'h54 : 8'h00);
      end
    end
  end
  // State and bus registers; rs/dat only load when a new byte enters SETUP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= PWR;
      ph <= SETUP;
      cnt <= '0;
      ii <= '0;
      r <= '0;
      c <= '0;
      lcd_rs <= 1'b0;
      lcd_dat <= 8'h00;
      lcd_en <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st <= st_n;
      ph <= ph_n;
      cnt <= cnt_n;
      ii <= ii_n;
      r <= r_n;
      c <= c_n;
      lcd_rs <= rs_n;
      lcd_dat <= dat_n;
      lcd_en <= ph_n == HIGH;
      done_q <= done_q | init_last;
    end
  end
  // Frame buffer; same-edge write/latch collision sends the old byte
  always_ff @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < N; i++) mem[i] <= 8'h20;
    else if (wr_en && {1'b0, wr_addr} < N_L) mem[wr_addr] <= wr_data;
  end
endmodule
